// File: rtl/keypad_scanner_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scanner_pkg
// Shared types and constants for the 4x4 matrix keypad scanner.
//   state_t        : scanner FSM states
//   KEY_W / COLS   : key-code nibble width and column count
//   ROWS / IDX_W   : row count and row/column index width
//   COL_RESET      : one-hot-low column drive selected after reset (column 0)
//   col_index()    : index of the low bit of a one-hot-low column pattern
//   lowest_low_row(): index of the lowest-numbered low row
// -----------------------------------------------------------------------------
package keypad_scanner_pkg;

  localparam int KEY_W = 4;
  localparam int COLS  = 4;
  localparam int ROWS  = 4;
  localparam int IDX_W = 2;

  localparam logic [COLS-1:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  function automatic logic [IDX_W-1:0] col_index(input logic [COLS-1:0] cols_n);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < COLS; i++) begin
      if (!cols_n[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Scans from the top down so the lowest-numbered low row is the one kept.
  function automatic logic [IDX_W-1:0] lowest_low_row(input logic [ROWS-1:0] rows_n);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_tick.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Free-running divider producing the scan/debounce time base.
//   clk  : system clock
//   rst  : synchronous active-high reset (counter to 0)
//   tick : high for one clk whenever the counter is all-ones; the counter
//          then wraps to 0, so the period is 2^SCAN_DIV_BITS clk
// -----------------------------------------------------------------------------
module scan_tick_gen #(
  parameter int SCAN_DIV_BITS = 11
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [SCAN_DIV_BITS-1:0] DIV_ONE = SCAN_DIV_BITS'(1);

  logic [SCAN_DIV_BITS-1:0] div_cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= div_cnt + DIV_ONE;
  end

  assign tick = &div_cnt;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// 4x4 matrix keypad scanner with press/release debounce and a hex entry
// shift register.
//   clk       : system clock (posedge)
//   rst       : synchronous active-high reset
//   row_n     : keypad rows, active-low, asynchronous to clk
//   col_n     : column drive, one-hot-low
//   key_valid : one-clk pulse per accepted key press
//   key_code  : row*4 + col of the last accepted key
//   value     : entry register, newest key in the low nibble
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = 11,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic [31:0]      value
);

  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);

  logic             tick;
  logic [ROWS-1:0]  row_meta;
  logic [ROWS-1:0]  rs;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [IDX_W-1:0] col_idx;
  logic [IDX_W-1:0] row_idx;
  logic [KEY_W-1:0] new_code;

  logic any_low;
  logic row_hit;
  logic col_rotate;
  logic key_latch;
  logic cnt_clr;
  logic cnt_step;
  logic accept;

  scan_tick_gen #(
    .SCAN_DIV_BITS(SCAN_DIV_BITS)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer; idle (all high) after reset so no phantom press.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= '1;
      rs       <= '1;
    end else begin
      row_meta <= row_n;
      rs       <= row_meta;
    end
  end

  assign any_low  = (rs != '1);
  assign row_hit  = ~rs[row_idx];
  assign cnt_inc  = cnt + CNT_ONE;
  assign new_code = {row_idx, col_idx};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= SCAN;
    else     state <= state_next;
  end

  // Next-state logic; the FSM only moves on ticks.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    if (tick) begin
      unique case (state)
        SCAN:     if (any_low) state_next = DEBOUNCE;
        DEBOUNCE: begin
          if (!row_hit)                state_next = SCAN;
          else if (cnt_inc == CNT_DONE) state_next = HELD;
        end
        HELD:     if (!any_low) state_next = RELEASE;
        RELEASE:  begin
          if (any_low)                 state_next = HELD;
          else if (cnt_inc == CNT_DONE) state_next = SCAN;
        end
        default:  state_next = SCAN;
      endcase
    end
  end

  // Output/control decode driving the datapath below.
  always_comb begin
    col_rotate = 1'b0;
    key_latch  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_step   = 1'b0;
    accept     = 1'b0;
    if (tick) begin
      unique case (state)
        SCAN: begin
          col_rotate = ~any_low;
          key_latch  = any_low;
          cnt_clr    = any_low;
        end
        DEBOUNCE: begin
          cnt_step = row_hit;
          accept   = row_hit && (cnt_inc == CNT_DONE);
        end
        HELD:    cnt_clr  = ~any_low;
        RELEASE: cnt_step = ~any_low;
        default: ;
      endcase
    end
  end

  // Column drive, key latch, debounce counter and the registered accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_n     <= COL_RESET;
      col_idx   <= '0;
      row_idx   <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      value     <= '0;
    end else begin
      key_valid <= accept;
      if (col_rotate) col_n <= {col_n[COLS-2:0], col_n[COLS-1]};
      if (key_latch) begin
        col_idx <= col_index(col_n);
        row_idx <= lowest_low_row(rs);
      end
      if (cnt_clr)       cnt <= '0;
      else if (cnt_step) cnt <= cnt_inc;
      if (accept) begin
        key_code <= new_code;
        value    <= {value[31-KEY_W:0], new_code};
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Bench for keypad_scanner with SCAN_DIV_BITS=2 (tick every 4 clk) and
// DEBOUNCE_TICKS=2. Stimulus is applied on tick boundaries counted from the
// last reset edge; each expected accept is queued when the press is driven
// and compared when key_valid pulses.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int TICK_CLKS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n = 4'hF;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] value;

  keypad_scanner #(
    .SCAN_DIV_BITS (2),
    .DEBOUNCE_TICKS(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .value     (value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] value;
  } exp_t;

  typedef struct {
    int          row;
    int          col;
    logic [31:0] value_after;
  } key_vec_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_vec      = 0;
  int          n_bad      = 0;
  int          n_pulses   = 0;
  int          n_expected = 0;
  logic [31:0] exp_value  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Every key_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      n_pulses++;
      if (sb_q.size() == 0) begin
        check("unexpected_key_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("key_code", {28'd0, key_code}, {28'd0, mon_e.code});
        check("value_at_pulse", value, mon_e.value);
      end
    end
  end

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  function automatic logic [3:0] row_pat(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << r);
  endfunction

  // Leaves the bench 1 time unit after the last reset edge (tick phase 0).
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_value = '0;
  endtask

  task automatic do_ticks(input int n);
    repeat (n * TICK_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input int c);
    for (int i = 0; i < 8; i++) begin
      if (col_n === col_pat(c)) return;
      do_ticks(1);
    end
    check("wait_col_timeout", {28'd0, col_n}, {28'd0, col_pat(c)});
  endtask

  // Press (row,col) for hold ticks, then release and wait out the release
  // debounce so the FSM is back in SCAN.
  task automatic press_key(input int row, input int col, input int hold);
    logic [3:0] code;
    code = 4'(row * 4 + col);
    wait_col(col);
    exp_value = {exp_value[27:0], code};
    sb_q.push_back('{code, exp_value});
    n_expected++;
    row_n = row_pat(row);
    do_ticks(hold);
    row_n = 4'hF;
    do_ticks(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_n"},     {28'd0, col_n},    32'h0000_000E);
    check({tag, "_key_valid"}, {31'd0, key_valid}, 32'd0);
    check({tag, "_key_code"},  {28'd0, key_code}, 32'd0);
    check({tag, "_value"},     value,             32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  key_vec_t keys[9];

  initial begin
    keys[0] = '{0, 1, 32'h0000_0001};
    keys[1] = '{0, 2, 32'h0000_0012};
    keys[2] = '{0, 3, 32'h0000_0123};
    keys[3] = '{1, 0, 32'h0000_1234};
    keys[4] = '{1, 1, 32'h0001_2345};
    keys[5] = '{1, 2, 32'h0012_3456};
    keys[6] = '{1, 3, 32'h0123_4567};
    keys[7] = '{2, 0, 32'h1234_5678};
    keys[8] = '{2, 1, 32'h2345_6789};

    // Reset state, then 40 idle clk: column advances every 4 clk.
    do_reset();
    check_reset_outputs("reset");
    for (int j = 0; j < 40; j++) begin
      check("idle_col_n", {28'd0, col_n}, {28'd0, col_pat((j / 4) % 4)});
      @(posedge clk);
      #1;
    end
    check("idle_value", value, 32'd0);

    // Row 2 held in column 1: column frozen until the release is debounced.
    do_reset();
    wait_col(1);
    sb_q.push_back('{4'h9, 32'h0000_0009});
    n_expected++;
    row_n = row_pat(2);
    for (int i = 0; i < 5; i++) begin
      do_ticks(1);
      check("held_col_n", {28'd0, col_n}, 32'h0000_000D);
    end
    row_n = 4'hF;
    for (int i = 0; i < 3; i++) begin
      do_ticks(1);
      check("release_col_n", {28'd0, col_n}, 32'h0000_000D);
    end
    do_ticks(1);
    check("resume_col_n", {28'd0, col_n}, 32'h0000_000B);
    check("single_value", value, 32'h0000_0009);
    check("single_pulses", n_pulses, n_expected);

    // One-tick bounce: no accept, scan resumes from the held column.
    do_reset();
    wait_col(2);
    row_n = row_pat(0);
    do_ticks(1);
    check("bounce_detect_col", {28'd0, col_n}, {28'd0, col_pat(2)});
    row_n = 4'hF;
    do_ticks(1);
    check("bounce_back_col", {28'd0, col_n}, {28'd0, col_pat(2)});
    do_ticks(1);
    check("bounce_rotate_col", {28'd0, col_n}, {28'd0, col_pat(3)});
    check("bounce_value", value, 32'd0);
    check("bounce_pulses", n_pulses, n_expected);

    // Nine keys, codes 1..9; the first nibble is shifted out.
    do_reset();
    foreach (keys[k]) begin
      press_key(keys[k].row, keys[k].col, 3);
      check("seq_value", value, keys[k].value_after);
    end
    check("seq_pulses", n_pulses, n_expected);

    // Rows 1 and 3 together in column 0: lowest row wins. While held, a
    // 3-tick partial release and a 2-tick full release must not re-accept.
    do_reset();
    wait_col(0);
    sb_q.push_back('{4'h4, 32'h0000_0004});
    n_expected++;
    row_n = 4'b0101;
    do_ticks(3);
    row_n = 4'b0111;
    do_ticks(3);
    row_n = 4'b0101;
    do_ticks(1);
    row_n = 4'hF;
    do_ticks(2);
    row_n = 4'b0101;
    do_ticks(2);
    check("multi_held_col", {28'd0, col_n}, {28'd0, col_pat(0)});
    row_n = 4'hF;
    do_ticks(3);
    check("multi_release_col", {28'd0, col_n}, {28'd0, col_pat(0)});
    do_ticks(1);
    check("multi_resume_col", {28'd0, col_n}, {28'd0, col_pat(1)});
    check("multi_code", {28'd0, key_code}, 32'h0000_0004);
    check("multi_pulses", n_pulses, n_expected);

    // Reset during DEBOUNCE.
    do_reset();
    press_key(2, 1, 3);
    wait_col(2);
    row_n = row_pat(0);
    do_ticks(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_debounce");
    row_n = 4'hF;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_value = '0;

    // Reset landing on the accepting tick edge.
    press_key(2, 1, 3);
    wait_col(2);
    row_n = row_pat(0);
    do_ticks(2);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_accept");
    row_n = 4'hF;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_value = '0;
    do_ticks(4);
    check("rst_pulses", n_pulses, n_expected);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
